openila_capture_ctrl: RTL and testbench
=======================================

OPENILA_CAPTURE_CTRL -- requirements
Module: openila_capture_ctrl

Interface
REQ-001 SHALL have parameter W_DATA, default 9, meaning the width of a compressed sample word and of a memory word.
REQ-002 SHALL have parameter W_ADDR, default 8, meaning the memory address width; depth D = 2^W_ADDR.
REQ-003 SHALL have port clk  input  1  sole clock; all logic rising-edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port arm  input  1  single-cycle pulse that starts a new capture.
REQ-006 SHALL have port trigger  input  1  trigger hit from the trigger unit.
REQ-007 SHALL have port din  input  W_DATA  compressed sample from the compressor.
REQ-008 SHALL have port din_valid  input  1  qualifies din, one beat per cycle.
REQ-009 SHALL have port post_count  input  W_ADDR  number of post-trigger writes, sampled on the trigger cycle.
REQ-010 SHALL have port mem_addr  output  W_ADDR  memory address.
REQ-011 SHALL have port mem_wen  output  1  memory write enable.
REQ-012 SHALL have port mem_wdata  output  W_DATA  memory write data.
REQ-013 SHALL have port mem_rdata  input  W_DATA  memory read data, valid one cycle after mem_addr.
REQ-014 SHALL have port rd_start  input  1  pulse that starts readout.
REQ-015 SHALL have port rd_data  output  W_DATA  readout word.
REQ-016 SHALL have port rd_valid  output  1  readout word valid.
REQ-017 SHALL have port rd_ready  input  1  readout consumer ready.
REQ-018 SHALL have port status  output  3  {done, triggered, armed}.

Function
REQ-019 SHALL have the states IDLE, ARMED, POST, DONE, RD_ADDR, RD_DATA and RD_OUT.
REQ-020 SHALL, on arm in any state, go to ARMED, clear wr_ptr, clear the wrapped flag and clear rd_valid; arm has priority over every other input.
REQ-021 SHALL, in ARMED and POST, write din to wr_ptr when din_valid is high (mem_wen=1, mem_addr=wr_ptr, mem_wdata=din, combinational from din), then increment wr_ptr modulo D.
REQ-022 SHALL set the wrapped flag when wr_ptr increments from D-1 to 0.
REQ-023 SHALL ignore din_valid in IDLE, DONE and the RD_* states (mem_wen=0).
REQ-024 SHALL, in ARMED with trigger high:
  - write the same-cycle din beat as a pre-trigger sample;
  - latch remain=post_count;
  - go to POST if post_count is nonzero, otherwise to DONE.
REQ-025 SHALL, in POST, decrement remain on each write and go to DONE on the write that makes remain 0; trigger is ignored outside ARMED.
REQ-026 SHALL, in DONE on rd_start, set rd_ptr to wr_ptr if wrapped, else 0, set rd_left to D if wrapped, else wr_ptr, and go to RD_ADDR if rd_left is nonzero, otherwise stay in DONE.
REQ-027 SHALL, in RD_ADDR, drive mem_addr=rd_ptr with mem_wen=0 and go to RD_DATA.
REQ-028 SHALL, in RD_DATA, register mem_rdata into rd_data, set rd_valid and go to RD_OUT.
REQ-029 SHALL, in RD_OUT, hold rd_data and rd_valid stable until rd_ready is high.
REQ-030 SHALL, on the rd_valid&&rd_ready handshake in RD_OUT:
  - clear rd_valid;
  - increment rd_ptr modulo D;
  - decrement rd_left;
  - go to RD_ADDR, or to DONE if rd_left becomes 0.
REQ-031 SHALL emit words oldest to newest, one word per 3 cycles at most.
REQ-032 SHALL drive mem_addr=wr_ptr outside RD_ADDR.
REQ-033 SHALL keep rd_left W_ADDR+1 bits wide.
REQ-034 SHALL allow a further rd_start in DONE to replay the same buffer.
REQ-035 SHALL drive status.armed=1 in ARMED, status.triggered=1 in POST, and status.done=1 in DONE and the RD_* states.

Reset
REQ-036 SHALL, while rst_n is low, force IDLE, wr_ptr=0, rd_ptr=0, remain=0, rd_left=0, wrapped=0, rd_data=0, rd_valid=0, mem_wen=0, mem_addr=0 and status=0, including mid-capture and mid-readout.
REQ-037 SHALL, after rst_n deasserts, accept no writes until arm.

Verification
REQ-038 SHALL cover, with W_ADDR=4, arm, din=1..20 one per cycle, trigger with sample 10 and post_count=4: writes 1..14, DONE, not wrapped; rd_start reads out 1..14 in order, then rd_valid stays 0.
REQ-039 SHALL cover, with W_ADDR=4, the same stimulus but trigger with sample 20: 24 writes, wrapped=1; readout is exactly 16 words, 9..24.
REQ-040 SHALL cover post_count=0 with trigger on sample 5: DONE on the next cycle; readout 1..5; samples arriving after the trigger cycle are not written.
REQ-041 SHALL cover rd_ready held low for 10 cycles in RD_OUT: rd_valid=1 and rd_data unchanged for all 10 cycles, and the word is consumed once rd_ready rises.
REQ-042 SHALL cover arm pulsed during readout (word 3 pending): next cycle rd_valid=0, status=001, and the next write lands at mem_addr 0.
REQ-043 SHALL cover rst_n pulsed low during POST: all outputs go to their reset values immediately, and no mem_wen occurs until a new arm.

Source files
------------

// File: rtl/openila_capture_ctrl.sv
// ---------------------------------------------------------------------------
// openila_capture_ctrl
//
// Capture and readout controller for a small integrated logic analyser.
// After an arm pulse, compressed samples are written into a circular sample
// memory. A trigger hit latches how many post-trigger samples to keep. Once
// those have been written the buffer is frozen. A readout pass then streams
// the buffer oldest-to-newest through a valid/ready port. It waits one memory
// read latency per word.
//
// Parameters
//   W_DATA     width of a compressed sample word and of a memory word
//   W_ADDR     memory address width, buffer depth is 2**W_ADDR
//
// Ports
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   arm        single-cycle pulse, starts a new capture (highest priority)
//   trigger    trigger hit from the trigger unit
//   din        compressed sample
//   din_valid  qualifies din
//   post_count number of post-trigger writes, sampled on the trigger cycle
//   mem_addr   memory address (write pointer, or read pointer during RD_ADDR)
//   mem_wen    memory write enable
//   mem_wdata  memory write data (combinational from din)
//   mem_rdata  memory read data, valid one cycle after mem_addr
//   rd_start   starts a readout pass of the frozen buffer
//   rd_data    readout word
//   rd_valid   readout word valid
//   rd_ready   readout consumer ready
//   status     {done, triggered, armed}
// ---------------------------------------------------------------------------
module openila_capture_ctrl #(
    parameter int W_DATA = 9,
    parameter int W_ADDR = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              arm,
    input  logic              trigger,
    input  logic [W_DATA-1:0] din,
    input  logic              din_valid,
    input  logic [W_ADDR-1:0] post_count,
    output logic [W_ADDR-1:0] mem_addr,
    output logic              mem_wen,
    output logic [W_DATA-1:0] mem_wdata,
    input  logic [W_DATA-1:0] mem_rdata,
    input  logic              rd_start,
    output logic [W_DATA-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [2:0]        status
);

    // Full buffer depth expressed in the rd_left width. It needs one extra bit
    // so that a wrapped buffer can report all 2**W_ADDR words.
    localparam logic [W_ADDR:0]   DEPTH_L = {1'b1, {W_ADDR{1'b0}}};
    localparam logic [W_ADDR-1:0] ONE_A   = {{(W_ADDR-1){1'b0}}, 1'b1};
    localparam logic [W_ADDR:0]   ONE_L   = {{W_ADDR{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        POST,
        DONE,
        RD_ADDR,
        RD_DATA,
        RD_OUT
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [W_ADDR-1:0] wr_ptr;
    logic [W_ADDR-1:0] rd_ptr;
    logic [W_ADDR-1:0] remain;
    logic [W_ADDR:0]   rd_left;
    logic              wrapped;

    logic              wr_fire;
    logic              handshake;
    logic [W_ADDR:0]   start_len;

    // A write happens only while capturing. An arm pulse suppresses the write
    // in its own cycle because the pointer is being cleared anyway.
    assign wr_fire   = (state == ARMED || state == POST) && din_valid && !arm;
    assign handshake = (state == RD_OUT) && rd_valid && rd_ready;

    // Number of words a readout pass covers. A buffer that has wrapped is
    // completely full. Otherwise the words are those written since the arm.
    assign start_len = wrapped ? DEPTH_L : {1'b0, wr_ptr};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. Arm overrides everything and restarts the capture from
    // any state, including the middle of a readout.
    always_comb begin
        state_next = state;
        if (arm) begin
            state_next = ARMED;
        end else begin
            case (state)
                IDLE:    state_next = IDLE;
                ARMED: begin
                    if (trigger) begin
                        state_next = (post_count != '0) ? POST : DONE;
                    end
                end
                POST: begin
                    if (wr_fire && remain == ONE_A) begin
                        state_next = DONE;
                    end
                end
                DONE: begin
                    if (rd_start && start_len != '0) begin
                        state_next = RD_ADDR;
                    end
                end
                RD_ADDR: state_next = RD_DATA;
                RD_DATA: state_next = RD_OUT;
                RD_OUT: begin
                    if (handshake) begin
                        state_next = (rd_left == ONE_L) ? DONE : RD_ADDR;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Output logic. The memory address is the write pointer except for the
    // single cycle in which the read pointer is presented to the memory.
    always_comb begin
        mem_wen   = wr_fire;
        mem_wdata = din;
        mem_addr  = (state == RD_ADDR) ? rd_ptr : wr_ptr;
        status    = 3'b000;
        case (state)
            ARMED:                         status = 3'b001;
            POST:                          status = 3'b010;
            DONE, RD_ADDR, RD_DATA, RD_OUT: status = 3'b100;
            default:                       status = 3'b000;
        endcase
    end

    // Pointers, counters and readout register. The wrapped flag records that
    // the write pointer has passed the end of the memory at least once. When
    // it is set, the oldest surviving sample sits at the current write pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            remain   <= '0;
            rd_left  <= '0;
            wrapped  <= 1'b0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else if (arm) begin
            wr_ptr   <= '0;
            wrapped  <= 1'b0;
            rd_valid <= 1'b0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= wr_ptr + ONE_A;
                if (wr_ptr == '1) begin
                    wrapped <= 1'b1;
                end
            end
            case (state)
                ARMED: begin
                    if (trigger) begin
                        remain <= post_count;
                    end
                end
                POST: begin
                    if (wr_fire) begin
                        remain <= remain - ONE_A;
                    end
                end
                DONE: begin
                    if (rd_start) begin
                        rd_ptr  <= wrapped ? wr_ptr : '0;
                        rd_left <= start_len;
                    end
                end
                RD_DATA: begin
                    rd_data  <= mem_rdata;
                    rd_valid <= 1'b1;
                end
                RD_OUT: begin
                    if (handshake) begin
                        rd_valid <= 1'b0;
                        rd_ptr   <= rd_ptr + ONE_A;
                        rd_left  <= rd_left - ONE_L;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_openila_capture_ctrl.sv
// ---------------------------------------------------------------------------
// tb_openila_capture_ctrl
//
// Bench for openila_capture_ctrl with a 16-deep buffer. A synchronous sample
// memory with one-cycle read latency is modelled alongside the DUT.
//
// The expected memory writes and readout words are derived from the capture
// rules:
//   - sample k of a capture lands at address (k-1) mod 16;
//   - a readout yields the last min(N, 16) of the N captured samples.
// A compare process checks these against every write and every consumed word.
// Directed checks cover status, stalls, re-arm and reset.
// ---------------------------------------------------------------------------
module tb_openila_capture_ctrl;

    localparam int W_DATA = 9;
    localparam int W_ADDR = 4;
    localparam int DEPTH  = 16;

    logic              clk        = 1'b0;
    logic              rst_n      = 1'b0;
    logic              arm        = 1'b0;
    logic              trigger    = 1'b0;
    logic [W_DATA-1:0] din        = '0;
    logic              din_valid  = 1'b0;
    logic [W_ADDR-1:0] post_count = '0;
    logic              rd_start   = 1'b0;
    logic              rd_ready   = 1'b0;
    logic [W_ADDR-1:0] mem_addr;
    logic              mem_wen;
    logic [W_DATA-1:0] mem_wdata;
    logic [W_DATA-1:0] mem_rdata;
    logic [W_DATA-1:0] rd_data;
    logic              rd_valid;
    logic [2:0]        status;

    logic [W_DATA-1:0] mem [DEPTH];

    int checks = 0;
    int errors = 0;

    int exp_wr_addr[$];
    int exp_wr_data[$];
    int exp_rd[$];

    openila_capture_ctrl #(
        .W_DATA(W_DATA),
        .W_ADDR(W_ADDR)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .arm       (arm),
        .trigger   (trigger),
        .din       (din),
        .din_valid (din_valid),
        .post_count(post_count),
        .mem_addr  (mem_addr),
        .mem_wen   (mem_wen),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .rd_start  (rd_start),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .status    (status)
    );

    // Clock generation.
    always #5 clk = ~clk;

    // Sample memory with one-cycle read latency.
    always @(posedge clk) begin
        if (mem_wen) begin
            mem[mem_addr] <= mem_wdata;
        end
        mem_rdata <= mem[mem_addr];
    end

    // Compare process: every write and every consumed readout word must match
    // the front of the corresponding expectation queue.
    always @(negedge clk) begin : compare_proc
        int a;
        int d;
        if (rst_n) begin
            if (mem_wen) begin
                checks++;
                if (exp_wr_addr.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_write: got addr %0d data %0d, required no write",
                             mem_addr, mem_wdata);
                end else begin
                    a = exp_wr_addr.pop_front();
                    d = exp_wr_data.pop_front();
                    if (mem_addr !== W_ADDR'(a) || mem_wdata !== W_DATA'(d)) begin
                        errors++;
                        $display("[TB] FAIL write: got addr %0d data %0d, required addr %0d data %0d",
                                 mem_addr, mem_wdata, a, d);
                    end
                end
            end
            if (rd_valid && rd_ready) begin
                checks++;
                if (exp_rd.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_word: got %0d, required no word", rd_data);
                end else begin
                    d = exp_rd.pop_front();
                    if (rd_data !== W_DATA'(d)) begin
                        errors++;
                        $display("[TB] FAIL readout: got %0d, required %0d", rd_data, d);
                    end
                end
            end
        end
    end

    // Directed comparison helper.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then return 1 time unit after the next edge.
    task automatic applyStimulus(input logic a, input logic t, input logic dv,
                                 input logic [W_DATA-1:0] d, input logic [W_ADDR-1:0] pc,
                                 input logic rs, input logic rr);
        arm        = a;
        trigger    = t;
        din_valid  = dv;
        din        = d;
        post_count = pc;
        rd_start   = rs;
        rd_ready   = rr;
        @(posedge clk);
        #1;
    endtask

    // Expected writes: samples first.. land at consecutive addresses from 0.
    task automatic model_capture(input int first, input int count);
        for (int i = 0; i < count; i++) begin
            exp_wr_addr.push_back(i % DEPTH);
            exp_wr_data.push_back(first + i);
        end
    endtask

    // Expected readout: the newest min(n, DEPTH) samples, oldest first.
    task automatic model_readout(input int first, input int n);
        int keep;
        keep = (n >= DEPTH) ? DEPTH : n;
        for (int i = n - keep; i < n; i++) begin
            exp_rd.push_back(first + i);
        end
    endtask

    // Start a readout with rd_ready high and drain it within a cycle budget.
    task automatic run_readout(input string name, output int cyc);
        applyStimulus(0, 0, 0, '0, '0, 1, 1);
        cyc = 0;
        while (exp_rd.size() > 0 && cyc < 200) begin
            applyStimulus(0, 0, 0, '0, '0, 0, 1);
            cyc++;
        end
        checkOutput({name, "_drained"}, exp_rd.size(), 0);
    endtask

    initial begin : main
        int cyc;
        $display("[TB] start");

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_status", status, 0);
        checkOutput("rst_mem_wen", mem_wen, 0);
        checkOutput("rst_mem_addr", mem_addr, 0);
        checkOutput("rst_rd_valid", rd_valid, 0);
        checkOutput("rst_rd_data", rd_data, 0);
        rst_n = 1'b1;

        // No writes before the first arm.
        for (int k = 1; k <= 4; k++) applyStimulus(0, (k == 2), 1, W_DATA'(k), 4'd4, 0, 1);
        checkOutput("idle_status", status, 0);

        // Capture 1: trigger on sample 10, post_count 4, no wrap.
        model_capture(1, 14);
        applyStimulus(1, 0, 0, '0, 4'd4, 0, 1);
        checkOutput("s1_armed", status, 3'b001);
        for (int k = 1; k <= 20; k++) begin
            applyStimulus(0, (k == 10), 1, W_DATA'(k), 4'd4, 0, 1);
            if (k == 10) checkOutput("s1_post", status, 3'b010);
            if (k == 14) checkOutput("s1_done", status, 3'b100);
        end
        checkOutput("s1_writes_done", exp_wr_addr.size(), 0);
        checkOutput("s1_wr_ptr", mem_addr, 14);
        model_readout(1, 14);
        checkOutput("model_s1_oldest", exp_rd[0], 1);
        run_readout("s1", cyc);
        checkOutput("s1_last_word", rd_data, 14);
        repeat (5) applyStimulus(0, 0, 0, '0, '0, 0, 1);
        checkOutput("s1_valid_after", rd_valid, 0);
        checkOutput("s1_status_after", status, 3'b100);

        // Capture 2: trigger on sample 20, buffer wraps.
        model_capture(1, 24);
        applyStimulus(1, 0, 0, '0, 4'd4, 0, 1);
        for (int k = 1; k <= 28; k++) applyStimulus(0, (k == 20), 1, W_DATA'(k), 4'd4, 0, 1);
        checkOutput("s2_writes_done", exp_wr_addr.size(), 0);
        checkOutput("s2_wr_ptr", mem_addr, 8);
        checkOutput("s2_status", status, 3'b100);
        model_readout(1, 24);
        checkOutput("model_s2_oldest", exp_rd[0], 9);
        checkOutput("model_s2_len", exp_rd.size(), 16);
        run_readout("s2", cyc);
        checkOutput("s2_rate", (cyc >= 3 * 16), 1);
        checkOutput("s2_last_word", rd_data, 24);
        // Replay of the same frozen buffer.
        model_readout(1, 24);
        run_readout("s2_replay", cyc);
        checkOutput("s2_replay_last", rd_data, 24);

        // Capture 3: post_count 0, trigger on sample 5.
        model_capture(1, 5);
        applyStimulus(1, 0, 0, '0, '0, 0, 1);
        for (int k = 1; k <= 10; k++) begin
            applyStimulus(0, (k == 5), 1, W_DATA'(k), '0, 0, 1);
            if (k == 5) checkOutput("s3_done", status, 3'b100);
        end
        checkOutput("s3_writes_done", exp_wr_addr.size(), 0);
        checkOutput("s3_wr_ptr", mem_addr, 5);
        // Readout with the consumer stalled on the first word.
        model_readout(1, 5);
        applyStimulus(0, 0, 0, '0, '0, 1, 0);
        cyc = 0;
        while (!rd_valid && cyc < 20) begin
            applyStimulus(0, 0, 0, '0, '0, 0, 0);
            cyc++;
        end
        checkOutput("s3_valid_seen", rd_valid, 1);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 0, 0, '0, '0, 0, 0);
            checkOutput("s3_stall_valid", rd_valid, 1);
            checkOutput("s3_stall_data", rd_data, 1);
        end
        cyc = 0;
        while (exp_rd.size() > 0 && cyc < 100) begin
            applyStimulus(0, 0, 0, '0, '0, 0, 1);
            cyc++;
        end
        checkOutput("s3_drained", exp_rd.size(), 0);

        // Re-arm while word 3 of a replay is pending.
        model_readout(1, 5);
        applyStimulus(0, 0, 0, '0, '0, 1, 1);
        cyc = 0;
        while (exp_rd.size() > 3 && cyc < 50) begin
            applyStimulus(0, 0, 0, '0, '0, 0, 1);
            cyc++;
        end
        checkOutput("s4_two_consumed", exp_rd.size(), 3);
        cyc = 0;
        while (!rd_valid && cyc < 10) begin
            applyStimulus(0, 0, 0, '0, '0, 0, 0);
            cyc++;
        end
        checkOutput("s4_word3_pending", rd_data, 3);
        exp_rd.delete();
        model_capture(100, 3);
        applyStimulus(1, 0, 1, W_DATA'(99), 4'd4, 0, 0);
        checkOutput("s4_rd_valid", rd_valid, 0);
        checkOutput("s4_status", status, 3'b001);
        checkOutput("s4_mem_addr", mem_addr, 0);

        // Capture into POST, then reset asynchronously mid-cycle.
        for (int k = 1; k <= 3; k++) applyStimulus(0, (k == 2), 1, W_DATA'(99 + k), 4'd4, 0, 1);
        checkOutput("s5_post", status, 3'b010);
        checkOutput("s5_writes_done", exp_wr_addr.size(), 0);
        rst_n = 1'b0;
        #1;
        checkOutput("s5_rst_status", status, 0);
        checkOutput("s5_rst_mem_wen", mem_wen, 0);
        checkOutput("s5_rst_mem_addr", mem_addr, 0);
        checkOutput("s5_rst_rd_valid", rd_valid, 0);
        checkOutput("s5_rst_rd_data", rd_data, 0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 1; k <= 5; k++) applyStimulus(0, (k == 1), 1, W_DATA'(k), 4'd4, 0, 1);
        checkOutput("s5_idle_status", status, 0);
        checkOutput("s5_idle_addr", mem_addr, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
